// File: rtl/cpu_pkg.sv
// Shared data-memory constants: MMIO register offsets and error-register bit positions.
package cpu_pkg;

    localparam logic [3:0] MMIO_TX_DATA   = 4'h0;
    localparam logic [3:0] MMIO_TX_STATUS = 4'h4;
    localparam logic [3:0] MMIO_CYCLE     = 4'h8;
    localparam logic [3:0] MMIO_ERR       = 4'hC;

    typedef enum logic [1:0] {
        ERR_MISALIGN = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_OVERFLOW = 2'd2
    } err_bit_e;

    localparam int ERR_W = 3;

endpackage

// File: rtl/console_fifo.sv
// Console TX byte FIFO, first-word-fall-through; one-cycle push-to-visible latency.
// A push while full is accepted only if a pop happens in the same cycle.
module console_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Storage is not reset, so gate the head to keep the output clean while empty.
    assign data_o  = empty_o ? '0 : buf_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) buf_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO window (console FIFO, cycle counter, sticky errors).
// Loads are combinational in the request cycle; stores and side effects commit on the clock edge.
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  console_data_o,
    output logic        console_valid_o,
    input  logic        console_ready_i,
    output logic        error_o
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0]      ram_q [MEM_WORDS];
    logic [31:0]      cycle_q, cycle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             error_q;

    logic [31:0] mmio_off;
    logic [3:0]  reg_off;
    logic        aligned, ram_hit, mmio_hit, access;
    logic        ram_wr, tx_push, cyc_wr, err_wr;
    logic        tx_pop, tx_full, tx_empty;
    logic [CW-1:0] tx_count;

    assign aligned  = (mem_addr_i[1:0] == 2'b00);
    assign ram_hit  = (mem_addr_i < RAM_BYTES);
    assign mmio_off = mem_addr_i - MMIO_BASE;
    assign mmio_hit = (mmio_off < 32'd16);
    assign reg_off  = mmio_off[3:0];
    assign access   = mem_re_i || mem_we_i;

    assign ram_wr  = mem_we_i && aligned && ram_hit;
    assign tx_push = mem_we_i && aligned && mmio_hit && (reg_off == MMIO_TX_DATA);
    assign cyc_wr  = mem_we_i && aligned && mmio_hit && (reg_off == MMIO_CYCLE);
    assign err_wr  = mem_we_i && aligned && mmio_hit && (reg_off == MMIO_ERR);

    assign console_valid_o = !tx_empty;
    assign tx_pop          = console_valid_o && console_ready_i;
    assign error_o         = error_q;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (tx_push),
        .push_data_i (mem_wdata_i[7:0]),
        .pop_i       (tx_pop),
        .data_o      (console_data_o),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_count)
    );

    // Clear-on-write happens first so errors raised by this same access survive it.
    always_comb begin
        err_d = err_q;
        if (err_wr) err_d = '0;
        if (access && !aligned) err_d[ERR_MISALIGN] = 1'b1;
        if (access && aligned && !ram_hit && !mmio_hit) err_d[ERR_UNMAPPED] = 1'b1;
        if (tx_push && tx_full && !tx_pop) err_d[ERR_OVERFLOW] = 1'b1;

        cycle_d = cycle_q + 32'd1;
        if (cyc_wr) cycle_d = mem_wdata_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cycle_q <= '0;
            err_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            err_q   <= err_d;
            error_q <= |err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_wr) ram_q[mem_addr_i[AW+1:2]] <= mem_wdata_i;
    end

    always_comb begin
        mem_rdata_o = '0;
        if (mem_re_i && aligned) begin
            if (ram_hit) begin
                mem_rdata_o = ram_q[mem_addr_i[AW+1:2]];
            end else if (mmio_hit) begin
                case (reg_off)
                    MMIO_TX_STATUS: mem_rdata_o = {16'b0, 8'(tx_count), 6'b0, tx_full, tx_empty};
                    MMIO_CYCLE:     mem_rdata_o = cycle_q;
                    MMIO_ERR:       mem_rdata_o = {{(32-ERR_W){1'b0}}, err_q};
                    default:        mem_rdata_o = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios then random traffic against a queue/array model.
module tb_data_mem_responder;

    localparam int          DEPTH = 8;
    localparam logic [31:0] MB    = 32'hFFFF_0000;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic        mem_re_i, mem_we_i;
    logic [7:0]  console_data_o;
    logic        console_valid_o, console_ready_i, error_o;

    data_mem_responder dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_re_i        (mem_re_i),
        .mem_we_i        (mem_we_i),
        .mem_rdata_o     (mem_rdata_o),
        .console_data_o  (console_data_o),
        .console_valid_o (console_valid_o),
        .console_ready_i (console_ready_i),
        .error_o         (error_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic [31:0] m_cyc;
    logic [2:0]  m_err;

    // Last sampled DUT outputs
    logic [31:0] obs_rdata;
    logic [7:0]  obs_data;
    logic        obs_valid, obs_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 misaligned, 1 RAM, 2 MMIO, 3 unmapped
    function automatic int kind_of(input logic [31:0] a);
        if (a[1:0] != 2'b00)           return 0;
        if (a < 32'd4096)              return 1;
        if (a >= MB && a <= MB + 32'hC) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] model_rdata(input logic re, input logic [31:0] a);
        int k;
        logic [31:0] off, sz;
        if (!re) return 32'h0;
        k = kind_of(a);
        if (k == 1) return m_ram[int'(a >> 2)];
        if (k != 2) return 32'h0;
        off = a - MB;
        sz  = 32'(m_q.size());
        case (off)
            32'h4:   return (sz << 8) | ((sz == DEPTH) ? 32'h2 : 32'h0) | ((sz == 0) ? 32'h1 : 32'h0);
            32'h8:   return m_cyc;
            32'hC:   return {29'b0, m_err};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rdy);
        int k;
        logic [31:0] off;
        logic [2:0] newerr;
        bit pop;
        mem_re_i = re; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata;
        console_ready_i = rdy;
        #4;
        obs_rdata = mem_rdata_o; obs_data = console_data_o;
        obs_valid = console_valid_o; obs_err = error_o;
        check("rdata", mem_rdata_o, model_rdata(re, addr));
        check("valid", 32'(console_valid_o), (m_q.size() != 0) ? 32'd1 : 32'd0);
        check("cdata", 32'(console_data_o), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check("error_o", 32'(error_o), (m_err != 3'b0) ? 32'd1 : 32'd0);
        // Advance the reference model by one clock edge
        k = kind_of(addr);
        off = addr - MB;
        newerr = 3'b0;
        pop = (m_q.size() != 0) && rdy;
        if (re || we) begin
            if (k == 0) newerr[0] = 1'b1;
            else if (k == 3) newerr[1] = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        if (we && k == 2 && off == 32'h0) begin
            if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
            else newerr[2] = 1'b1;
        end
        if (we && k == 2 && off == 32'hC) m_err = 3'b0;
        m_err = m_err | newerr;
        if (we && k == 2 && off == 32'h8) m_cyc = wdata;
        else m_cyc = m_cyc + 32'd1;
        if (we && k == 1) m_ram[int'(addr >> 2)] = wdata;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        mem_re_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = MB + 32'h8; mem_wdata_i = 32'h0;
        reset_i = 1'b1;
        #1;
        check("rst_valid", 32'(console_valid_o), 32'd0);
        check("rst_cdata", 32'(console_data_o), 32'd0);
        check("rst_error_o", 32'(error_o), 32'd0);
        check("rst_cycle", mem_rdata_o, 32'd0);
        m_q.delete(); m_err = 3'b0; m_cyc = 32'd0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        mem_re_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        reset_i = 1'b1; mem_re_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = 32'h0; mem_wdata_i = 32'h0; console_ready_i = 1'b0;
        do_reset();

        // RAM store/load, zero word, read-during-write
        step(0, 1, 32'h0, 32'hCAFE_F00D, 0);
        step(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
        step(1, 0, 32'h10, 32'h0, 0);
        check("t1_load", obs_rdata, 32'hDEAD_BEEF);
        step(0, 1, 32'h14, 32'h0, 0);
        step(1, 0, 32'h14, 32'h0, 0);
        check("t1_zero", obs_rdata, 32'h0);
        step(1, 1, 32'h10, 32'h1234_5678, 0);
        check("t1_rdw", obs_rdata, 32'hDEAD_BEEF);

        // Two bytes queued, then drained in order
        step(0, 1, MB, 32'h48, 0);
        step(0, 1, MB, 32'h69, 0);
        step(1, 0, MB + 32'h4, 32'h0, 0);
        check("t2_status", obs_rdata, 32'h0000_0200);
        step(0, 0, 32'h0, 32'h0, 1);
        check("t2_b0", 32'(obs_data), 32'h48);
        step(0, 0, 32'h0, 32'h0, 1);
        check("t2_b1", 32'(obs_data), 32'h69);
        step(0, 0, 32'h0, 32'h0, 1);
        check("t2_empty", 32'(obs_valid), 32'd0);

        // Overflow on the ninth push, then ERR clear
        for (int i = 0; i < 9; i++) step(0, 1, MB, 32'h30 + 32'(i), 0);
        step(1, 0, MB + 32'hC, 32'h0, 0);
        check("t3_err", obs_rdata, 32'h4);
        check("t3_error_o", 32'(obs_err), 32'd1);
        step(0, 1, MB + 32'hC, 32'h0, 0);
        step(1, 0, MB + 32'hC, 32'h0, 0);
        check("t3_clr", obs_rdata, 32'h0);

        // Push into a full FIFO while it pops
        step(0, 1, MB, 32'h55, 1);
        step(1, 0, MB + 32'h4, 32'h0, 0);
        check("t4_status", obs_rdata, 32'h0000_0802);
        for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 32'h0, 1);
        check("t4_last", 32'(obs_data), 32'h55);

        // Misaligned and unmapped accesses
        step(1, 0, 32'h12, 32'h0, 0);
        check("t5_mis_rd", obs_rdata, 32'h0);
        step(1, 0, MB + 32'hC, 32'h0, 0);
        check("t5_mis_err", obs_rdata, 32'h1);
        step(0, 1, MB + 32'hC, 32'h0, 0);
        step(0, 1, 32'h0000_8000, 32'hAAAA_AAAA, 0);
        step(1, 0, 32'h0, 32'h0, 0);
        check("t5_ram_kept", obs_rdata, 32'hCAFE_F00D);
        step(1, 0, MB + 32'hC, 32'h0, 0);
        check("t5_unm_err", obs_rdata, 32'h2);
        step(0, 1, MB + 32'hC, 32'h0, 0);

        // Counter load and wrap
        step(0, 1, MB + 32'h8, 32'hFFFF_FFFE, 0);
        step(1, 0, MB + 32'h8, 32'h0, 0);
        step(1, 0, MB + 32'h8, 32'h0, 0);
        check("t6_ffff", obs_rdata, 32'hFFFF_FFFF);
        step(1, 0, MB + 32'h8, 32'h0, 0);
        check("t6_wrap", obs_rdata, 32'h0);

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) step(0, 1, MB, 32'hA0 + 32'(i), 0);
        step(0, 0, 32'h0, 32'h0, 1);
        do_reset();
        step(0, 0, 32'h0, 32'h0, 1);
        check("t6_flushed", 32'(obs_valid), 32'd0);

        // Random traffic; RAM reads stay within initialised words
        for (int i = 0; i < 16; i++) step(0, 1, 32'(i * 4), $urandom, 0);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = 32'($urandom_range(0, 15)) * 4;
                2:       a = MB + 32'($urandom_range(0, 3)) * 4;
                3:       a = MB + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(1, 3));
                4:       a = 32'h1000 + 32'($urandom_range(0, 4095)) * 4;
                default: begin
                    a = $urandom;
                    if (a < 32'd4096) a = a | 32'h0010_0000;
                end
            endcase
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
